// File: rtl/channel_minmax_scan.sv
// Per-channel min/max scan over one RGB444 frame; publishes a coherent
// max/min/flat set on the final pixel for the contrast-stretch ALU.
module channel_minmax_scan #(
    parameter int unsigned NUM_PIXELS = 76800,
    parameter int unsigned CNT_W      = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pix_valid,
    input  logic [11:0]      pix_in,
    output logic             pix_ready,
    output logic [11:0]      max_out,
    output logic [11:0]      min_out,
    output logic [2:0]       flat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pix_count
);

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_W   = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [11:0] run_max, run_min;
    logic [11:0] run_max_nxt, run_min_nxt;
    logic [2:0]  flat_nxt;
    logic        launch;
    logic        accept;
    logic        last;

    // abort blocks the handshake so a cancelled scan never touches results
    assign launch = (state == IDLE) && start && !abort;
    assign accept = (state == SCAN) && pix_valid && !abort;
    assign last   = accept && (pix_count == LAST_IDX);

    assign pix_ready = (state == SCAN);
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);

    // Running extrema including the current pixel, plus flatness of that result
    always_comb begin
        run_max_nxt = run_max;
        run_min_nxt = run_min;
        flat_nxt    = 3'b000;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pix_in[c*CH_W +: CH_W] > run_max[c*CH_W +: CH_W])
                run_max_nxt[c*CH_W +: CH_W] = pix_in[c*CH_W +: CH_W];
            if (pix_in[c*CH_W +: CH_W] < run_min[c*CH_W +: CH_W])
                run_min_nxt[c*CH_W +: CH_W] = pix_in[c*CH_W +: CH_W];
            flat_nxt[c] = (run_max_nxt[c*CH_W +: CH_W] == run_min_nxt[c*CH_W +: CH_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = SCAN;
            SCAN: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Running registers, pixel counter and published results
    always_ff @(posedge clk) begin
        if (rst) begin
            run_max   <= 12'h000;
            run_min   <= 12'hFFF;
            pix_count <= '0;
            max_out   <= 12'hFFF;
            min_out   <= 12'h000;
            flat      <= 3'b000;
        end else begin
            if (launch) begin
                run_max   <= 12'h000;
                run_min   <= 12'hFFF;
                pix_count <= '0;
            end
            if (accept) begin
                run_max   <= run_max_nxt;
                run_min   <= run_min_nxt;
                pix_count <= pix_count + CNT_W'(1);
            end
            if (last) begin
                max_out <= run_max_nxt;
                min_out <= run_min_nxt;
                flat    <= flat_nxt;
            end
        end
    end

endmodule

// File: tb/tb_channel_minmax_scan.sv
// Directed bench for channel_minmax_scan with a 4-pixel frame.
module tb_channel_minmax_scan;

    localparam int unsigned NP    = 4;
    localparam int unsigned CNT_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             pix_valid;
    logic [11:0]      pix_in;
    logic             pix_ready;
    logic [11:0]      max_out;
    logic [11:0]      min_out;
    logic [2:0]       flat;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pix_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] prev_max;
    logic [11:0] prev_min;
    logic [2:0]  prev_flat;

    typedef struct {
        logic [3:0][11:0] pixels;   // pixels[3] is sent first
        int               gap;
        logic [11:0]      emax;
        logic [11:0]      emin;
        logic [2:0]       eflat;
    } vec_t;

    vec_t vecs[5];

    channel_minmax_scan #(.NUM_PIXELS(NP), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .pix_ready (pix_ready),
        .max_out   (max_out),
        .min_out   (min_out),
        .flat      (flat),
        .busy      (busy),
        .done      (done),
        .pix_count (pix_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                pix_valid = 1'b0;
                tick();
                check($sformatf("v%0d gap_busy", idx), 32'(busy), 32'd1);
                check($sformatf("v%0d gap_count", idx), 32'(pix_count), 32'(i));
            end
            pix_valid = 1'b1;
            pix_in    = v.pixels[3-i];
            check($sformatf("v%0d pix_ready", idx), 32'(pix_ready), 32'd1);
            tick();
            pix_valid = 1'b0;
            if (i < 3) begin
                check($sformatf("v%0d mid_done", idx), 32'(done), 32'd0);
                check($sformatf("v%0d mid_max_stable", idx), 32'(max_out), 32'(prev_max));
                check($sformatf("v%0d mid_min_stable", idx), 32'(min_out), 32'(prev_min));
                check($sformatf("v%0d mid_flat_stable", idx), 32'(flat), 32'(prev_flat));
            end
        end
        check($sformatf("v%0d done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d max_out", idx), 32'(max_out), 32'(v.emax));
        check($sformatf("v%0d min_out", idx), 32'(min_out), 32'(v.emin));
        check($sformatf("v%0d flat", idx), 32'(flat), 32'(v.eflat));
        check($sformatf("v%0d pix_count", idx), 32'(pix_count), 32'd4);
        check($sformatf("v%0d busy_in_done", idx), 32'(busy), 32'd0);
        tick();
        check($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
        check($sformatf("v%0d ready_idle", idx), 32'(pix_ready), 32'd0);
        prev_max  = v.emax;
        prev_min  = v.emin;
        prev_flat = v.eflat;
    endtask

    initial begin
        vecs[0] = '{{12'h777, 12'h777, 12'h777, 12'h777}, 0, 12'h777, 12'h777, 3'b111};
        vecs[1] = '{{12'h0F0, 12'h0F0, 12'h0F1, 12'h0F0}, 0, 12'h0F1, 12'h0F0, 3'b110};
        vecs[2] = '{{12'hF00, 12'h0F0, 12'h00F, 12'h888}, 1, 12'hFFF, 12'h000, 3'b000};
        vecs[3] = '{{12'h3A5, 12'h812, 12'h0F7, 12'hC4B}, 0, 12'hCFB, 12'h012, 3'b000};
        vecs[4] = '{{12'h3A5, 12'h812, 12'h0F7, 12'hC4B}, 3, 12'hCFB, 12'h012, 3'b000};

        // Reset with random inputs
        rst       = 1'b1;
        start     = 1'($urandom);
        abort     = 1'($urandom);
        pix_valid = 1'($urandom);
        pix_in    = 12'($urandom);
        tick();
        tick();
        check("rst max_out", 32'(max_out), 32'hFFF);
        check("rst min_out", 32'(min_out), 32'h000);
        check("rst flat", 32'(flat), 32'd0);
        check("rst pix_ready", 32'(pix_ready), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst pix_count", 32'(pix_count), 32'd0);
        rst = 1'b0; start = 1'b0; abort = 1'b0; pix_valid = 1'b0; pix_in = 12'h000;
        prev_max = 12'hFFF; prev_min = 12'h000; prev_flat = 3'b000;
        tick();

        for (int k = 0; k < 5; k++) run_frame(vecs[k], k);

        // start+abort together in IDLE stays IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle busy", 32'(busy), 32'd0);

        // Abort mid-scan, with an ignored start while scanning
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1; pix_in = 12'hFFF;
        tick();
        pix_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ignored count", 32'(pix_count), 32'd1);
        check("restart_ignored busy", 32'(busy), 32'd1);
        pix_valid = 1'b1; pix_in = 12'h000;
        tick();
        pix_valid = 1'b0;
        check("scan count2", 32'(pix_count), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort max_out", 32'(max_out), 32'hCFB);
        check("abort min_out", 32'(min_out), 32'h012);
        check("abort pix_count", 32'(pix_count), 32'd2);
        tick();
        check("abort no_late_done", 32'(done), 32'd0);

        // Abort coinciding with the final accept
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_in = 12'hFFF;
            tick();
        end
        pix_valid = 1'b1; pix_in = 12'h000; abort = 1'b1;
        tick();
        pix_valid = 1'b0; abort = 1'b0;
        check("final_abort done", 32'(done), 32'd0);
        check("final_abort ready", 32'(pix_ready), 32'd0);
        check("final_abort max_out", 32'(max_out), 32'hCFB);
        check("final_abort min_out", 32'(min_out), 32'h012);
        tick();
        check("final_abort no_late_done", 32'(done), 32'd0);

        // Reset during a scan
        start = 1'b1;
        tick();
        start = 1'b0;
        pix_valid = 1'b1; pix_in = 12'h5A5;
        tick();
        tick();
        pix_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst max_out", 32'(max_out), 32'hFFF);
        check("midrst min_out", 32'(min_out), 32'h000);
        check("midrst flat", 32'(flat), 32'd0);
        check("midrst pix_count", 32'(pix_count), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/channel_minmax_scan.md
Name: channel_minmax_scan

Overview:
- Upstream statistics stage for the per-pixel image ALU.
- Scans one frame of RGB444 pixels (12-bit, {R[11:8], G[7:4], B[3:0]}) and tracks the per-channel minimum and maximum.
- At frame end, publishes stable max/min words. These drive the ALU's contrast-stretch max/min inputs.
- Also flags flat channels (max == min) so the controller can avoid the divide-by-zero contrast case.

Parameters:
- NUM_PIXELS, 76800, pixels per frame (320x240); legal range 1..2^CNT_W-1.
- CNT_W, 17, width of the pixel counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a frame scan (honoured only in IDLE)
- abort  in  1  pulse; cancels an in-progress scan
- pix_valid  in  1  pix_in is valid this cycle
- pix_in  in  12  pixel {R,G,B} 4 bits each
- pix_ready  out  1  block accepts a pixel this cycle
- max_out  out  12  latched per-channel maxima {Rmax,Gmax,Bmax}
- min_out  out  12  latched per-channel minima {Rmin,Gmin,Bmin}
- flat  out  3  {R,G,B} channel max==min, latched with max_out/min_out
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse; new results valid
- pix_count  out  CNT_W  pixels accepted in current/last scan

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; max_out=12'hFFF; min_out=12'h000; flat=3'b000; done=0; busy=0; pix_count=0; running regs run_max=12'h000, run_min=12'hFFF.
- States: IDLE, SCAN, DONE. All outputs are registered or decoded from state; there is no combinational path from pix_valid to pix_ready.
- pix_ready=1 only in SCAN. busy=1 only in SCAN. done=1 only in DONE.
- IDLE:
  - start=1 and abort=0 -> SCAN.
  - Same edge: run_max=12'h000, run_min=12'hFFF, pix_count=0.
- SCAN, accept (pix_valid & pix_ready):
  - Per channel c independently: run_max[c]=max(run_max[c], pix_in[c]); run_min[c]=min(run_min[c], pix_in[c]). Compares are unsigned 4-bit.
  - pix_count += 1.
- SCAN, last pixel: accept with pix_count==NUM_PIXELS-1 -> DONE.
  - On that same edge, max_out/min_out are loaded with the running values including the final pixel, and flat[c]=(max==min) is computed from those final values.
- Latency: done is high in the cycle immediately after the final pixel's accepting edge, with the new outputs already visible in that cycle.
- DONE: one cycle only -> IDLE unconditionally. start is ignored in DONE.
- SCAN, no pixel: pix_valid=0 is a stall; state and counters hold. There is no timeout.
- abort:
  - In SCAN, abort=1 -> IDLE next edge. max_out, min_out and flat keep their previous values; done is not asserted; pix_count holds the partial count.
  - abort takes priority over a simultaneous final-pixel accept: no output update, no done.
  - abort in IDLE or DONE has no effect beyond normal transitions; start+abort together in IDLE stays IDLE.
- start while in SCAN is ignored.
- Output stability: max_out, min_out and flat change only on the final-pixel edge of a completed scan (or on reset). They are never partially updated mid-frame, so the downstream ALU always sees a coherent pair.
- pix_count saturation: never exceeds NUM_PIXELS; it cannot wrap because SCAN exits at NUM_PIXELS.
- rst mid-scan: immediate return to the reset values above; the partial frame is discarded.

Test Plan:
- Apply rst for 2 cycles with random inputs -> max_out=0xFFF, min_out=0x000, flat=000, pix_ready=0, done=0, pix_count=0.
- NUM_PIXELS=4; start, then back-to-back pixels 0x3A5, 0x812, 0x0F7, 0xC4B -> one cycle after the 4th accept: done=1 for exactly 1 cycle, max_out=0xCFB, min_out=0x012, flat=000, pix_count=4; next cycle state IDLE, pix_ready=0.
- Same four pixels with pix_valid low for 3 cycles between each pixel -> identical results; pix_count increments only on valid cycles; busy=1 throughout the gaps.
- NUM_PIXELS=4, all pixels 0x777 -> max_out=0x777, min_out=0x777, flat=111. Then a frame of 0x0F0, 0x0F0, 0x0F1, 0x0F0 -> max_out=0x0F1, min_out=0x0F0, flat=110.
- After a completed frame (0xCFB/0x012):
  - Start, accept 2 pixels (0xFFF, 0x000), assert abort -> IDLE, no done, max_out/min_out still 0xCFB/0x012, pix_count=2.
  - Start again mid-scan: ignored, pix_count not cleared.
- Start a 4-pixel frame and assert abort on the same cycle as the 4th accept -> no done, outputs unchanged. Then assert rst during a later SCAN -> all outputs return to reset values the next cycle.
